mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between the instruction-fetch requester (I-side, read-only) and the data requester (D-side, read/write with byte mask) of the pipelined RV32I core.
- Sits between the fetch/MEM stages and physical memory.
- Owns a 3-state grant FSM and latches the granted request onto registered memory-side outputs until memory responds.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; wmask width is DATA_W/8

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
i_read  in  1  I-side read request; held until i_resp
i_addr  in  ADDR_W  I-side address
i_rdata  out  DATA_W  I-side read data, valid when i_resp=1
i_resp  out  1  I-side one-cycle completion pulse
d_read  in  1  D-side read request; held until d_resp
d_write  in  1  D-side write request; held until d_resp
d_addr  in  ADDR_W  D-side address
d_wdata  in  DATA_W  D-side write data
d_wmask  in  DATA_W/8  D-side byte-enable mask
d_rdata  out  DATA_W  D-side read data, valid when d_resp=1
d_resp  out  1  D-side one-cycle completion pulse
mem_read  out  1  memory read strobe, registered
mem_write  out  1  memory write strobe, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_wmask  out  DATA_W/8  memory byte mask, registered
mem_rdata  in  DATA_W  memory read data
mem_resp  in  1  memory completion, one cycle, any latency >=1

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Reset -> IDLE.
- On reset, all mem_* outputs are 0. i_resp and d_resp are 0.
- IDLE, at each edge:
  - d_req = d_read|d_write pending -> SERVE_D. Latch addr, wdata and wmask. Drive mem_write=d_write, mem_read=d_read&~d_write.
  - Else i_read -> SERVE_I. Latch i_addr. Drive mem_read=1, mem_wmask=0.
  - Else stay in IDLE with strobes 0.
- Default priority: D over I, fixed.
- SERVE_x: mem_* outputs hold their latched values. Requester input changes are ignored.
  - On mem_resp=1: x_resp=1 that same cycle (combinational from state & mem_resp). x_rdata = mem_rdata (passthrough; the non-served side's rdata is also mem_rdata but its resp stays 0).
  - At that edge: -> IDLE, strobes cleared to 0. mem_addr, wdata and wmask keep their last value.
- Latency:
  - Request visible in IDLE at edge k -> strobe high in cycle k+1.
  - mem_resp in cycle m -> x_resp in cycle m.
  - Return to IDLE at edge m+1.
  - A new grant appears at edge m+2 earliest: one bubble cycle between back-to-back transactions.
- d_read & d_write both 1: treated as write. mem_read=0.
- Writes: d_resp pulses on mem_resp. d_rdata content is don't-care.
- Requester drops its request mid-transaction: the transaction still completes and resp still pulses. A requester re-asserting in the pulse cycle gets a new transaction.
- Only one of i_resp/d_resp is ever high in a cycle. mem_read & mem_write are never both high.
- mem_resp while IDLE: ignored, no resp pulse.
- rst mid-transaction: next cycle is IDLE with all strobes 0. The outstanding memory access is abandoned (memory is reset by the same rst). No resp pulse.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - A 1-bit last_grant register, reset to I, so D wins the first tie.
  - When both sides request in IDLE, the side not in last_grant wins.
  - last_grant updates on every grant.
  - A single requester is granted regardless of last_grant.
- Undefined: fixed D-over-I priority as above, with no extra register.

Test Plan:
- Reset: assert rst 2 cycles with i_read=1 -> all mem_*=0 and i_resp=d_resp=0. First mem_read appears 1 cycle after rst drops.
- I read: i_read=1, i_addr=0x0000_0100; memory responds 3 cycles after strobe with 0xDEAD_BEEF -> mem_read=1, mem_addr=0x100 held 3 cycles. i_resp=1 with i_rdata=0xDEAD_BEEF for exactly 1 cycle. Strobe low next cycle.
- Tie, fixed priority: i_read=1 and d_write=1 in the same cycle, d_addr=0x200, d_wdata=0x1234_5678, d_wmask=4'b0011 -> D served first: mem_write=1, mem_wmask=0011. After d_resp, one bubble, then the I read is granted.
- Write+read both asserted: d_read=d_write=1 -> mem_write=1, mem_read=0.
- Reset mid-op: rst during SERVE_D before mem_resp -> next cycle IDLE, strobes 0, no d_resp. A later mem_resp is ignored.
- Round-robin (macro defined): both sides requesting continuously for 4 transactions -> grant order D, I, D, I. Without the macro -> D, D, D, D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and data access (read/write).
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority with alternating priority on ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_reg;
  logic   d_req;
  logic   grant_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data side held the most recent grant; resets to the fetch side so data wins the first tie.
  logic last_grant_reg;

  assign grant_d = d_req & (~i_read | ~last_grant_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (grant_d) begin
        last_grant_reg <= 1'b1;
      end else if (i_read) begin
        last_grant_reg <= 1'b0;
      end
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg <= SERVE_D;
            // Simultaneous read and write is treated as a write.
            mem_write <= d_write;
            mem_read  <= d_read & ~d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wmask <= d_wmask;
          end else if (i_read) begin
            state_reg <= SERVE_I;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            mem_wmask <= '0;
          end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Address/data/mask stay at their last values after completion.
          if (mem_resp) begin
            state_reg <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign i_resp  = (state_reg == SERVE_I) & mem_resp;
  assign d_resp  = (state_reg == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule
